uart_rx_monitor: RTL and testbench



---
 rtl/uart_rx_monitor_if.sv | 19 +
 rtl/uart_rx_monitor.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_rx_monitor.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_monitor_if.sv
// Byte stream from the UART receive monitor to log/checker logic.
// The master drives data/valid; the slave returns ready.
interface uart_rx_monitor_if;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready;

    modport master (
        output m_tdata,
        output m_tvalid,
        input  m_tready
    );

    modport slave (
        input  m_tdata,
        input  m_tvalid,
        output m_tready
    );
endinterface

// File: rtl/uart_rx_monitor.sv
// UART receive monitor: deframes 8N1 (8E1 with UART_RX_PARITY_EN defined) into a byte FIFO
// and keeps saturating error counters plus a wrapping received-byte count.
module uart_rx_monitor #(
    parameter int unsigned CLKS_PER_BIT = 4167,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                ser_rx,
    uart_rx_monitor_if.master   m,
    input  logic                err_clr,
    output logic [7:0]          frame_err_cnt,
    output logic [7:0]          parity_err_cnt,
    output logic                overflow,
    output logic [15:0]         rx_count,
    output logic                busy
);

    localparam int unsigned CntW  = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned AddrW = $clog2(FIFO_DEPTH);

    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2);
    localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_e;

    // Input synchronizer; both flops reset to the idle line level.
    logic rx_meta;
    logic rx_s;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= ser_rx;
            rx_s    <= rx_meta;
        end
    end

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic            par_bad_q, par_bad_d;
    logic            byte_done;
    logic            frame_inc;
`ifdef UART_RX_PARITY_EN
    logic            parity_inc;
`endif

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shift_q   <= '0;
            bit_idx_q <= '0;
            par_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            par_bad_q <= par_bad_d;
        end
    end

    // cnt_q holds the cycle index within the current bit; the start bit is sampled at
    // mid-bit, every later bit one full bit period after the previous sample.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        par_bad_d  = par_bad_q;
        byte_done  = 1'b0;
        frame_inc  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_inc = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d   = StStart;
                    cnt_d     = CntOne;
                    bit_idx_d = '0;
                    par_bad_d = 1'b0;
                end
            end
            StStart: begin
                cnt_d = cnt_q + CntOne;
                if (cnt_q == CntHalf) begin
                    cnt_d   = CntOne;
                    state_d = rx_s ? StIdle : StData;
                end
            end
            StData: begin
                cnt_d = cnt_q + CntOne;
                if (cnt_q == CntFull) begin
                    cnt_d     = CntOne;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                cnt_d = cnt_q + CntOne;
                if (cnt_q == CntFull) begin
                    cnt_d   = CntOne;
                    state_d = StStop;
                    if ((^shift_q) != rx_s) begin
                        par_bad_d  = 1'b1;
                        parity_inc = 1'b1;
                    end
                end
            end
`endif
            StStop: begin
                cnt_d = cnt_q + CntOne;
                if (cnt_q == CntFull) begin
                    if (rx_s) begin
                        byte_done = !par_bad_q;
                        state_d   = StIdle;
                    end else begin
                        frame_inc = 1'b1;
                        state_d   = StBreak;
                    end
                end
            end
            StBreak: begin
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q != StIdle);

    // Byte FIFO with one extra pointer bit to tell full from empty.
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [AddrW:0] wr_ptr_q, rd_ptr_q;
    logic           fifo_empty, fifo_full;
    logic           push, pop, drop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                        (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign pop        = m.m_tvalid && m.m_tready;
    assign push       = byte_done && (!fifo_full || pop);
    assign drop       = byte_done && !push;

    assign m.m_tvalid = !fifo_empty;
    assign m.m_tdata  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[AddrW-1:0]];

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= shift_q;
        end
    end

    // Status counters; err_clr wins over a same-cycle increment.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            frame_err_cnt <= '0;
            overflow      <= 1'b0;
            rx_count      <= '0;
        end else begin
            if (err_clr) begin
                frame_err_cnt <= '0;
            end else if (frame_inc && (frame_err_cnt != 8'hFF)) begin
                frame_err_cnt <= frame_err_cnt + 8'd1;
            end
            if (err_clr) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
            if (push) begin
                rx_count <= rx_count + 16'd1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            parity_err_cnt <= '0;
        end else if (err_clr) begin
            parity_err_cnt <= '0;
        end else if (parity_inc && (parity_err_cnt != 8'hFF)) begin
            parity_err_cnt <= parity_err_cnt + 8'd1;
        end
    end
`else
    assign parity_err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor with a scoreboard of expected delivered bytes.
// Build with UART_RX_PARITY_EN defined to exercise the 8E1 frame.
module tb_uart_rx_monitor;

    localparam int unsigned C = 16;
    localparam int unsigned D = 4;

    logic        ap_clk;
    logic        ap_rst;
    logic        ser_rx;
    logic        err_clr;
    logic [7:0]  frame_err_cnt;
    logic [7:0]  parity_err_cnt;
    logic        overflow;
    logic [15:0] rx_count;
    logic        busy;

    uart_rx_monitor_if bus ();

    uart_rx_monitor #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .ap_clk         (ap_clk),
        .ap_rst         (ap_rst),
        .ser_rx         (ser_rx),
        .m              (bus),
        .err_clr        (err_clr),
        .frame_err_cnt  (frame_err_cnt),
        .parity_err_cnt (parity_err_cnt),
        .overflow       (overflow),
        .rx_count       (rx_count),
        .busy           (busy)
    );

    int         n_checks;
    int         n_fails;
    logic [7:0] sb_q[$];
    int         cyc;
    int         fall_cyc;
    int         rise_cyc;
    logic       par_flip;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge ap_clk);
            cyc++;
        end
    end

    // Consumer side: every accepted byte must match the head of the scoreboard.
    initial begin
        logic tvalid_d;
        logic [7:0] exp_b;
        tvalid_d = 1'b0;
        rise_cyc = 0;
        forever begin
            @(negedge ap_clk);
            if (bus.m_tvalid && !tvalid_d) rise_cyc = cyc;
            tvalid_d = bus.m_tvalid;
            if (!ap_rst && bus.m_tvalid && bus.m_tready) begin
                check("sb_has_entry", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    exp_b = sb_q.pop_front();
                    check("rx_byte", bus.m_tdata, exp_b);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        ser_rx = b;
        wait_cyc(C);
    endtask

    // Start, data and (when enabled) parity bits; the caller drives the stop bit.
    task automatic send_body(input logic [7:0] d);
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
    endtask

    task automatic send(input logic [7:0] d, input logic stop_bit, input logic expect_byte);
        if (expect_byte) sb_q.push_back(d);
        send_body(d);
        drive_bit(stop_bit);
    endtask

    initial begin
        n_checks     = 0;
        n_fails      = 0;
        par_flip     = 1'b0;
        ap_rst       = 1'b1;
        ser_rx       = 1'b1;
        err_clr      = 1'b0;
        bus.m_tready = 1'b1;
        wait_cyc(3);
        ap_rst = 1'b0;
        wait_cyc(2);

        check("rst_tvalid", bus.m_tvalid, 0);
        check("rst_tdata", bus.m_tdata, 0);
        check("rst_frame_err", frame_err_cnt, 0);
        check("rst_parity_err", parity_err_cnt, 0);
        check("rst_overflow", overflow, 0);
        check("rst_rx_count", rx_count, 0);
        check("rst_busy", busy, 0);

        // Single character: latency from falling edge to m_tvalid.
        send(8'h55, 1'b1, 1'b1);
`ifdef UART_RX_PARITY_EN
        check("latency", 32'(rise_cyc - fall_cyc), 32'(2 + C / 2 + 10 * C + 1));
`else
        check("latency", 32'(rise_cyc - fall_cyc), 32'(2 + C / 2 + 9 * C + 1));
`endif
        check("rx_count_1", rx_count, 1);
        check("busy_after_byte", busy, 0);

        // Short low pulse is a glitch, not a start bit.
        ser_rx = 1'b0;
        wait_cyc(4);
        ser_rx = 1'b1;
        wait_cyc(30);
        check("glitch_busy", busy, 0);
        check("glitch_frame_err", frame_err_cnt, 0);
        check("glitch_rx_count", rx_count, 1);
        check("glitch_tvalid", bus.m_tvalid, 0);

        // Bad stop bit, held-low break, then a good character.
        send(8'hA5, 1'b0, 1'b0);
        wait_cyc(48);
        check("break_busy", busy, 1);
        ser_rx = 1'b1;
        wait_cyc(C);
        check("break_exit", busy, 0);
        check("frame_err_1", frame_err_cnt, 1);
        send(8'h3C, 1'b1, 1'b1);
        wait_cyc(4);
        check("frame_rx_count", rx_count, 2);
        check("frame_err_hold", frame_err_cnt, 1);

        ap_rst = 1'b1;
        wait_cyc(2);
        ap_rst = 1'b0;
        wait_cyc(2);
        check("rst2_rx_count", rx_count, 0);
        check("rst2_frame_err", frame_err_cnt, 0);

        // Overflow with the consumer stalled; first four bytes survive.
        bus.m_tready = 1'b0;
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, i <= D);
        check("ovf_flag", overflow, 1);
        check("ovf_rx_count", rx_count, D);
        check("ovf_tvalid", bus.m_tvalid, 1);
        check("ovf_head_stable", bus.m_tdata, 8'h01);
        bus.m_tready = 1'b1;
        wait_cyc(10);
        check("ovf_drained", bus.m_tvalid, 0);
        check("ovf_sb_empty", 32'(sb_q.size()), 0);
        err_clr = 1'b1;
        wait_cyc(1);
        err_clr = 1'b0;
        check("clr_overflow", overflow, 0);
        check("clr_rx_count", rx_count, D);

        // err_clr on the very cycle a bad stop bit is sampled.
        send_body(8'h99);
        ser_rx = 1'b0;
        wait_cyc(10);
        err_clr = 1'b1;
        wait_cyc(1);
        err_clr = 1'b0;
        check("clr_prio_frame_err", frame_err_cnt, 0);
        check("clr_prio_break", busy, 1);
        ser_rx = 1'b1;
        wait_cyc(C);
        check("clr_prio_rx_count", rx_count, D);

`ifdef UART_RX_PARITY_EN
        send(8'h81, 1'b1, 1'b1);
        wait_cyc(4);
        par_flip = 1'b1;
        send(8'h81, 1'b1, 1'b0);
        par_flip = 1'b0;
        wait_cyc(4);
        check("parity_err_1", parity_err_cnt, 1);
        check("parity_rx_count", rx_count, D + 1);
`else
        check("parity_tied", parity_err_cnt, 0);
`endif

        // Reset mid-character discards the partial byte and the FIFO.
        bus.m_tready = 1'b0;
        send(8'h11, 1'b1, 1'b0);
        check("pre_rst_tvalid", bus.m_tvalid, 1);
        ser_rx = 1'b0;
        wait_cyc(C);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        ser_rx = 1'b1;
        wait_cyc(C / 2);
        ap_rst = 1'b1;
        #2;
        check("mid_rst_tvalid", bus.m_tvalid, 0);
        check("mid_rst_tdata", bus.m_tdata, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rx_count", rx_count, 0);
        check("mid_rst_overflow", overflow, 0);
        wait_cyc(2);
        ap_rst = 1'b0;
        bus.m_tready = 1'b1;
        wait_cyc(20);
        send(8'h7E, 1'b1, 1'b1);
        wait_cyc(5);
        check("post_rst_rx_count", rx_count, 1);
        check("final_sb_empty", 32'(sb_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
